// File: rtl/space_invaders_pkg.sv
// Shared types and screen/bullet constants for the space invaders datapath.
// Pure declarations: no logic, no latency, no flow control.
package space_invaders_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    FLY      = 2'd2,
    COOLDOWN = 2'd3
  } bullet_state_t;

  localparam int SCREEN_W            = 640;
  localparam int SCREEN_H            = 480;
  localparam int COORD_W             = 10;
  localparam int CNT_W               = 8;
  localparam int DEF_BULLET_LEN      = 4;
  localparam int DEF_BULLET_STEP     = 4;
  localparam int DEF_COOLDOWN_FRAMES = 8;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous level.
// One-cycle pulse two clock edges after the level is captured; no backpressure.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_sync3;

endmodule

// File: rtl/bullet_controller.sv
// Player bullet FSM: launch on fire edge, climb one step per frame, retire, cool down.
// Fire edge to bullet_in/shot_fired in 2 cycles; edges outside IDLE are dropped.
module bullet_controller
  import space_invaders_pkg::*;
#(
  parameter int BULLET_LEN      = DEF_BULLET_LEN,
  parameter int BULLET_STEP     = DEF_BULLET_STEP,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               fire,
  input  logic               hit,
  input  logic [COORD_W-1:0] playerX,
  input  logic [COORD_W-1:0] playerY,
  output logic               bullet_in,
  output logic [COORD_W-1:0] bulletX,
  output logic [COORD_W-1:0] bulletY,
  output logic               shot_fired
);

  localparam logic [COORD_W-1:0] LEN_C  = COORD_W'(BULLET_LEN);
  localparam logic [COORD_W-1:0] STEP_C = COORD_W'(BULLET_STEP);
  localparam logic [CNT_W-1:0]   CD_C   = CNT_W'(COOLDOWN_FRAMES);

  bullet_state_t      r_state;
  bullet_state_t      w_state_nxt;
  logic [COORD_W-1:0] r_x, w_x_nxt;
  logic [COORD_W-1:0] r_y, w_y_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_shot, w_shot_nxt;
  logic               r_fire_q;
  logic               r_fire_arm;
  logic               w_fire_edge;
  logic               w_tick;

  sync_edge_detect u_frame_sync (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_async (frame_clk),
    .o_pulse (w_tick)
  );

  // r_fire_arm masks the first cycle after reset so a key held through reset is not seen as a press.
  assign w_fire_edge = fire & ~r_fire_q & r_fire_arm;

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    w_shot_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fire_edge) w_state_nxt = LAUNCH;
      end
      LAUNCH: begin
        if (playerY < LEN_C) begin
          w_state_nxt = IDLE;
        end else begin
          w_x_nxt     = playerX;
          w_y_nxt     = playerY - LEN_C;
          w_shot_nxt  = 1'b1;
          w_state_nxt = FLY;
        end
      end
      FLY: begin
        if (hit) begin
          w_state_nxt = COOLDOWN;
          w_cnt_nxt   = CD_C;
        end else if (w_tick) begin
          if (r_y < STEP_C) begin
            w_state_nxt = COOLDOWN;
            w_cnt_nxt   = CD_C;
          end else begin
            w_y_nxt = r_y - STEP_C;
          end
        end
      end
      COOLDOWN: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else if (w_tick) w_cnt_nxt = r_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_cnt      <= '0;
      r_shot     <= 1'b0;
      r_fire_q   <= 1'b0;
      r_fire_arm <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shot     <= w_shot_nxt;
      r_fire_q   <= fire;
      r_fire_arm <= 1'b1;
    end
  end

  assign bullet_in  = (r_state == FLY);
  assign bulletX    = r_x;
  assign bulletY    = r_y;
  assign shot_fired = r_shot;

endmodule
